// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line idle level, default baud divisor.
// Imported by the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } uart_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   CLKS_PER_BIT_DEF = 16;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud divider: bit_tick marks the last clk of each bit period,
// pre_tick the clk before it (lets the FSM register end-of-bit outputs).
import uart_pkg::*;

module uart_bit_timer #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = (cnt == LAST);
  assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops one byte per frame
// and serialises it LSB first as 8N1/8N2 on tx.
import uart_pkg::*;

module fifo_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              f_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              r_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_W - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t       state;
  logic [DATA_W-1:0] shift;
  logic [2:0]        bit_cnt;
  logic              bit_tick;
  logic              pre_tick;
  logic              tmr_clear;

  // Timer restarts from zero on entry to START.
  assign tmr_clear = (state == S_IDLE) ||
                     (state == S_FETCH) ||
                     (state == S_LATCH);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .bit_tick(bit_tick),
    .pre_tick(pre_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tx      <= UART_IDLE_LEVEL;
      r_en    <= 1'b0;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      shift   <= '0;
      bit_cnt <= '0;
    end else begin
      r_en    <= 1'b0;
      tx_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          tx <= UART_IDLE_LEVEL;
          if (enable && !f_empty) begin
            state <= S_FETCH;
            r_en  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          shift   <= fifo_data;
          bit_cnt <= '0;
          tx      <= ~UART_IDLE_LEVEL;
          state   <= S_START;
        end
        S_START: begin
          if (bit_tick) begin
            tx    <= shift[0];
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            shift <= shift >> 1;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              tx      <= UART_IDLE_LEVEL;
              state   <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift[1];
            end
          end
        end
        S_STOP: begin
          if (pre_tick && bit_cnt == LAST_STOP) begin
            tx_done <= 1'b1;
          end
          if (bit_tick) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              busy    <= 1'b0;
              state   <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx    <= UART_IDLE_LEVEL;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: two transmitters (4 clk/bit 1 stop, 16 clk/bit 2 stop)
// each fed by a 1-cycle-latency FIFO model.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       en0 = 1'b0;
  logic       fe0 = 1'b1;
  logic [7:0] fd0 = 8'h00;
  logic       ren0, tx0, busy0, done0;

  logic       en1 = 1'b0;
  logic       fe1 = 1'b1;
  logic [7:0] fd1 = 8'h00;
  logic       ren1, tx1, busy1, done1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .rst(rst), .enable(en0),
    .f_empty(fe0), .fifo_data(fd0),
    .r_en(ren0), .tx(tx0), .busy(busy0), .tx_done(done0)
  );

  fifo_uart_tx #(
    .DATA_W(8), .CLKS_PER_BIT(16), .STOP_BITS(2)
  ) dut1 (
    .clk(clk), .rst(rst), .enable(en1),
    .f_empty(fe1), .fifo_data(fd1),
    .r_en(ren1), .tx(tx1), .busy(busy1), .tx_done(done1)
  );

  always @(posedge clk) begin
    if (ren0 && q0.size() != 0) fd0 <= q0.pop_front();
    fe0 <= (q0.size() == 0);
    if (ren1 && q1.size() != 0) fd1 <= q1.pop_front();
    fe1 <= (q1.size() == 0);
  end

  function automatic logic g_tx(input int s);
    return s != 0 ? tx1 : tx0;
  endfunction
  function automatic logic g_ren(input int s);
    return s != 0 ? ren1 : ren0;
  endfunction
  function automatic logic g_busy(input int s);
    return s != 0 ? busy1 : busy0;
  endfunction
  function automatic logic g_done(input int s);
    return s != 0 ? done1 : done0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ren(input int s, input int budget);
    int n = 0;
    while (g_ren(s) !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    chk("ren_seen", 32'(g_ren(s)), 32'd1);
  endtask

  // Called in the r_en cycle; checks the whole frame and the IDLE cycle after it.
  task automatic frame(input int s, input logic [7:0] b, input int drop_k);
    int cpb = (s != 0) ? 16 : 4;
    int nst = (s != 0) ? 2 : 1;
    int total = (9 + nst) * cpb;
    int lvl;
    logic e;
    cyc();
    chk("latch_tx", 32'(g_tx(s)), 32'd1);
    chk("latch_busy", 32'(g_busy(s)), 32'd1);
    for (int k = 0; k < total; k++) begin
      cyc();
      lvl = k / cpb;
      if (lvl == 0) e = 1'b0;
      else if (lvl <= 8) e = b[lvl-1];
      else e = 1'b1;
      chk($sformatf("tx s%0d b%02h k%0d", s, b, k), 32'(g_tx(s)), 32'(e));
      chk($sformatf("done k%0d", k), 32'(g_done(s)), 32'(k == total - 1));
      chk($sformatf("ren k%0d", k), 32'(g_ren(s)), 32'd0);
      chk($sformatf("busy k%0d", k), 32'(g_busy(s)), 32'd1);
      if (k == drop_k) en0 = 1'b0;
    end
    cyc();
    chk("post_busy", 32'(g_busy(s)), 32'd0);
    chk("post_tx", 32'(g_tx(s)), 32'd1);
  endtask

  task automatic no_ren(input int s, input int n, input string tag);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (g_ren(s) === 1'b1) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    // reset held with FIFO non-empty and enable high
    q0.push_back(8'hA5);
    en0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_tx", 32'(tx0), 32'd1);
      chk("rst_ren", 32'(ren0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
    end
    rst = 1'b0;

    // single byte
    wait_ren(0, 20);
    frame(0, 8'hA5, -1);

    // three queued bytes, back to back
    q0.push_back(8'h00);
    q0.push_back(8'hFF);
    q0.push_back(8'h55);
    wait_ren(0, 20);
    frame(0, 8'h00, -1);
    cyc();
    chk("b2b_ren1", 32'(ren0), 32'd1);
    frame(0, 8'hFF, -1);
    cyc();
    chk("b2b_ren2", 32'(ren0), 32'd1);
    frame(0, 8'h55, -1);
    chk("fifo_empty", 32'(fe0), 32'd1);
    no_ren(0, 60, "no_4th_ren");

    // enable gating
    en0 = 1'b0;
    q0.push_back(8'h5A);
    q0.push_back(8'hC3);
    no_ren(0, 100, "disabled_ren");
    en0 = 1'b1;
    wait_ren(0, 20);
    frame(0, 8'h5A, 4 * 4 + 1);
    no_ren(0, 50, "after_drop_ren");

    // reset mid-frame
    q0.delete();
    cyc();
    cyc();
    q0.push_back(8'h3C);
    en0 = 1'b1;
    wait_ren(0, 20);
    repeat (23) cyc();
    chk("t5_bit4", 32'(tx0), 32'd1);
    chk("t5_busy_pre", 32'(busy0), 32'd1);
    rst = 1'b1;
    cyc();
    chk("t5_tx", 32'(tx0), 32'd1);
    chk("t5_busy", 32'(busy0), 32'd0);
    chk("t5_ren", 32'(ren0), 32'd0);
    rst = 1'b0;
    no_ren(0, 30, "t5_no_retry");
    q0.push_back(8'h96);
    wait_ren(0, 20);
    frame(0, 8'h96, -1);

    // 2 stop bits, 16 clk/bit
    q1.push_back(8'h81);
    en1 = 1'b1;
    wait_ren(1, 20);
    frame(1, 8'h81, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
